beat_sequencer: RTL
===================

# beat_sequencer

Parametrised beat-index sequencer for the audio path. It replaces the fixed 0..1200 free-running beat counter with a per-song end point, a tempo prescaler, play/pause/loop/one-shot modes, song switching and a fade-in volume ramp. It runs on the slow clk22 beat clock. Its outputs feed the song ROM (beat index, song number) and the note generator (volume, enable).

## Interface
Parameters:
- BEAT_W, 12, width of beat index and song_last
- SONG_W, 2, width of song select (up to 2^SONG_W songs)
- DIV_W, 4, width of tempo prescaler (clk22 ticks per beat = tempo_div+1)
- VOL_W, 2, width of volume output
- FADE_BEATS, 16, beat advances per volume step during fade-in (≥1)

Ports:
- clk22  in  1  beat clock
- rst  in  1  reset, asynchronous, active-high
- en  in  1  play enable; low forces IDLE
- pause  in  1  hold position while high
- loop  in  1  1 = restart at beat 0 after last beat, 0 = one-shot
- song_sel  in  SONG_W  requested song
- song_last  in  BEAT_W  last beat index of the currently latched song (from ROM)
- tempo_div  in  DIV_W  prescale compare value
- beat  out  BEAT_W  current beat index
- song  out  SONG_W  latched song number
- playing  out  1  high in PLAY state
- done  out  1  one-cycle pulse when last beat completes
- vol  out  VOL_W  fade-in volume

## Operation
States are IDLE, PLAY, PAUSE and DONE. Event priority per cycle, highest first: en low > song change > pause > beat advance.
- IDLE: beat=0, presc=0, vol=0, playing=0.
  - en=1 → PLAY; song<=song_sel; beat=0; fade counter=0.
- PLAY: presc increments each cycle.
  - Advance when presc ≥ tempo_div (≥, so a mid-beat reduction of tempo_div cannot overrun): presc<=0, beat<=beat+1.
  - Advance with beat==song_last:
    - loop=1 → beat<=0, done=1, stay PLAY.
    - loop=0 → DONE, done=1, beat holds song_last.
- song_sel≠song in PLAY, PAUSE or DONE → PLAY with song<=song_sel, beat=0, presc=0, vol=0, fade restarted; no done pulse.
- pause=1 in PLAY → PAUSE. beat, presc, vol and fade counter freeze. pause=0 → PLAY, resuming the same presc value.
- DONE: playing=0, vol=0, beat holds. Only en low (→ IDLE) or a song change leaves it. A loop change alone does not.
- en=0 in any state → IDLE next cycle and clears all counters.
- Fade:
  - A fade counter counts beat advances and wraps at FADE_BEATS-1.
  - Each wrap increments vol, saturating at all-ones.
  - After a loop wrap to beat 0, vol keeps its value; the fade does not restart.
- Width rules:
  - beat compare is equality against song_last.
  - beat never exceeds song_last. If song_last is reduced below beat, the next advance with beat>song_last is treated as the last beat.
  - song_last=0 gives a one-beat song.
  - tempo_div=0 gives an advance every cycle.

## Timing
- Reset values: state IDLE, beat=0, song=0, playing=0, done=0, vol=0, presc=0.
- All outputs are registered; no combinational input-to-output path.
- en rise at edge N → playing=1 and song valid after edge N+1. The first advance occurs tempo_div+1 cycles later.
- done is high for exactly the cycle following the advancing edge. It coincides with beat=0 (loop) or state DONE (one-shot).
- Asynchronous rst mid-song returns to reset values immediately. Playback restarts only from IDLE with en=1.

## Structure
- Package beat_seq_pkg:
  - state enum (IDLE, PLAY, PAUSE, DONE)
  - default parameter constants
  - vol saturation constant
- Sub-module tempo_prescaler:
  - DIV_W counter with clear, hold, compare-≥ and a tick output.
  - beat_sequencer instantiates one and owns the FSM, beat counter and fade logic.

## Test plan
- Reset, then en=1, song_sel=1, song_last=3, tempo_div=1, loop=1 → song=1; beat steps 0,1,2,3,0 every 2 cycles; done pulses once as beat goes 3→0.
- loop=0, song_last=2, tempo_div=0 → beat 0,1,2, then state DONE, playing=0, one done pulse, beat holds 2.
- pause held 5 cycles mid-beat → beat and vol frozen. After release, the next advance comes after the remaining presc count only.
- song_sel change while paused at beat 7 → next cycle state PLAY, beat=0, vol=0, no done pulse.
- FADE_BEATS=2, tempo_div=0, song_last=20 → vol 0,0,1,1,2,2,3 then saturates at 3.
- Assert rst at beat 5, and separately drop en in DONE → all outputs return to reset values; restart from beat 0.

Source files
------------

// File: rtl/beat_seq_pkg.sv
// Shared types and default constants for the beat sequencer.
package beat_seq_pkg;

    // Playback modes of the sequencer
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PLAY  = 2'd1,
        PAUSE = 2'd2,
        DONE  = 2'd3
    } state_t;

    // Default parameter values
    localparam int DEF_BEAT_W     = 12;
    localparam int DEF_SONG_W     = 2;
    localparam int DEF_DIV_W      = 4;
    localparam int DEF_VOL_W      = 2;
    localparam int DEF_FADE_BEATS = 16;

    // Full-scale volume at the default width; the ramp saturates here
    localparam logic [DEF_VOL_W-1:0] DEF_VOL_SAT = '1;

endpackage

// File: rtl/tempo_prescaler.sv
// Tempo prescaler: counts clk22 ticks within one beat and flags the advance.
// The compare is >= so that lowering tempo_div mid-beat cannot skip the advance.
module tempo_prescaler #(
    parameter int DIV_W = 4
) (
    input  logic             clk22,
    input  logic             rst,
    input  logic             clear,
    input  logic             hold,
    input  logic [DIV_W-1:0] tempo_div,
    output logic             tick
);

    logic [DIV_W-1:0] count_reg;
    logic [DIV_W-1:0] count_next;

    // Tick decode and next count: clear wins over hold, tick restarts the beat
    always_comb begin
        tick       = !clear && !hold && (count_reg >= tempo_div);
        count_next = count_reg;
        if (clear) begin
            count_next = '0;
        end else if (!hold) begin
            if (tick) begin
                count_next = '0;
            end else begin
                count_next = count_reg + DIV_W'(1);
            end
        end
    end

    // Prescale counter register
    always_ff @(posedge clk22 or posedge rst) begin
        if (rst) begin
            count_reg <= '0;
        end else begin
            count_reg <= count_next;
        end
    end

endmodule

// File: rtl/beat_sequencer.sv
// Beat-index sequencer: per-song end point, tempo prescaler, play/pause,
// loop/one-shot, song switching and a saturating fade-in volume ramp.
module beat_sequencer
    import beat_seq_pkg::*;
#(
    parameter int BEAT_W     = DEF_BEAT_W,
    parameter int SONG_W     = DEF_SONG_W,
    parameter int DIV_W      = DEF_DIV_W,
    parameter int VOL_W      = DEF_VOL_W,
    parameter int FADE_BEATS = DEF_FADE_BEATS
) (
    input  logic              clk22,
    input  logic              rst,
    input  logic              en,
    input  logic              pause,
    input  logic              loop,
    input  logic [SONG_W-1:0] song_sel,
    input  logic [BEAT_W-1:0] song_last,
    input  logic [DIV_W-1:0]  tempo_div,
    output logic [BEAT_W-1:0] beat,
    output logic [SONG_W-1:0] song,
    output logic              playing,
    output logic              done,
    output logic [VOL_W-1:0]  vol
);

    localparam int                FADE_W    = (FADE_BEATS > 1) ? $clog2(FADE_BEATS) : 1;
    localparam logic [FADE_W-1:0] FADE_LAST = FADE_W'(FADE_BEATS - 1);
    localparam logic [VOL_W-1:0]  VOL_SAT   = {VOL_W{1'b1}};

    state_t            state_reg, state_next;
    logic [BEAT_W-1:0] beat_reg, beat_next;
    logic [SONG_W-1:0] song_reg, song_next;
    logic [FADE_W-1:0] fade_reg, fade_next;
    logic [VOL_W-1:0]  vol_reg, vol_next;
    logic              done_reg, done_next;

    logic song_chg;
    logic presc_run;
    logic presc_clear;
    logic presc_tick;

    // Prescaler control, kept apart from the FSM so the tick path stays acyclic
    assign song_chg    = (song_sel != song_reg);
    assign presc_run   = en && (state_reg == PLAY) && !song_chg && !pause;
    assign presc_clear = !en || song_chg || (state_reg == IDLE) || (state_reg == DONE);

    tempo_prescaler #(
        .DIV_W (DIV_W)
    ) u_presc (
        .clk22     (clk22),
        .rst       (rst),
        .clear     (presc_clear),
        .hold      (!presc_run),
        .tempo_div (tempo_div),
        .tick      (presc_tick)
    );

    // Next state and counters; priority is en low, song change, pause, advance
    always_comb begin
        state_next = state_reg;
        beat_next  = beat_reg;
        song_next  = song_reg;
        fade_next  = fade_reg;
        vol_next   = vol_reg;
        done_next  = 1'b0;

        if (!en) begin
            state_next = IDLE;
            beat_next  = '0;
            song_next  = '0;
            fade_next  = '0;
            vol_next   = '0;
        end else if (state_reg == IDLE || song_chg) begin
            // Start (or restart) the requested song from the top, fade from silence
            state_next = PLAY;
            song_next  = song_sel;
            beat_next  = '0;
            fade_next  = '0;
            vol_next   = '0;
        end else begin
            case (state_reg)
                PLAY: begin
                    if (pause) begin
                        state_next = PAUSE;
                    end else if (presc_tick) begin
                        // Fade ramp counts every advance, including the last beat
                        if (fade_reg == FADE_LAST) begin
                            fade_next = '0;
                            if (vol_reg != VOL_SAT) begin
                                vol_next = vol_reg + VOL_W'(1);
                            end
                        end else begin
                            fade_next = fade_reg + FADE_W'(1);
                        end
                        // >= also catches a song_last that shrank below the position
                        if (beat_reg >= song_last) begin
                            done_next = 1'b1;
                            if (loop) begin
                                beat_next = '0;
                            end else begin
                                state_next = DONE;
                                beat_next  = song_last;
                                vol_next   = '0;
                            end
                        end else begin
                            beat_next = beat_reg + BEAT_W'(1);
                        end
                    end
                end
                PAUSE: begin
                    if (!pause) begin
                        state_next = PLAY;
                    end
                end
                DONE: begin
                    state_next = DONE;
                end
                default: begin
                    state_next = IDLE;
                end
            endcase
        end
    end

    // State and output registers
    always_ff @(posedge clk22 or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
            beat_reg  <= '0;
            song_reg  <= '0;
            fade_reg  <= '0;
            vol_reg   <= '0;
            done_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            beat_reg  <= beat_next;
            song_reg  <= song_next;
            fade_reg  <= fade_next;
            vol_reg   <= vol_next;
            done_reg  <= done_next;
        end
    end

    assign beat    = beat_reg;
    assign song    = song_reg;
    assign playing = (state_reg == PLAY);
    assign done    = done_reg;
    assign vol     = vol_reg;

endmodule
